hvsync_detector: RTL and testbench
==================================

// Module: hvsync_detector
// PURPOSE
//   Sink-side counterpart of the 640x480@60 sync generator: samples incoming negative-polarity hsync/vsync
//   in the 25 MHz pixel domain, recovers x/y screen position, and verifies line/frame timing.
//   Qualifies an external or looped-back video source before it feeds capture or overlay logic.
// PARAMETERS
//   H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48  -- horizontal timing, pixels
//   V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33  -- vertical timing, lines
//   Derived localparams: H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525)
// PORTS
//   clk_25        in   1   pixel clock; all logic on posedge
//   rst           in   1   asynchronous, active-high reset
//   hsync         in   1   incoming hsync, active low, synchronous to clk_25
//   vsync         in   1   incoming vsync, active low, synchronous to clk_25
//   x_count       out  10  recovered column, 0..H_TOTAL-1
//   y_count       out  10  recovered row, 0..V_TOTAL-1
//   active_pixel  out  1   locked && x_count<H_ACTIVE && y_count<V_ACTIVE (decode of current counters)
//   locked        out  1   timing verified, registered
//   timing_err    out  1   one-cycle pulse on loss of lock
//   line_period   out  11  last measured hsync fall-to-fall period, cycles
//   frame_lines   out  10  last measured line count between frame starts
// BEHAVIOUR
//   Reset (async): x_count=0, y_count=0, locked=0, timing_err=0, line_period=0, frame_lines=0;
//     state=SEARCH; hs_q=vs_q=1 (idle, no false edge); pend=0; per_cnt=0; line_cnt=0; err_f=0.
//   Edges: hs_fall = hs_q & ~hsync; vs_fall = vs_q & ~vsync; hs_q/vs_q register the inputs every cycle.
//   per_cnt (11b): hs_fall -> 1; else +1, saturating at 2047. On hs_fall: line_period <= per_cnt.
//   pend: set on vs_fall; cleared at the frame start that consumes it.
//   frame start (FS) = hs_fall && (pend || vs_fall); same-edge vs_fall+hs_fall counts as FS.
//   x_count: hs_fall -> H_ACTIVE+H_FP (656); else if x_count==H_TOTAL-1 -> 0; else +1.
//   y_count: FS -> V_ACTIVE+V_FP (490); else on x wrap (799->0) +1, V_TOTAL-1 wraps to 0; else hold.
//   line_cnt (10b): FS -> 1 and frame_lines <= line_cnt; other hs_fall -> +1, saturating at 1023.
//   per_bad = hs_fall && per_cnt!=H_TOTAL; lines_bad = FS && line_cnt!=V_TOTAL.
//   FSM (transitions on the edge where the condition is sampled):
//     SEARCH: FS -> VERIFY, err_f<=0.
//     VERIFY: per_bad sets err_f; at FS: if !err_f && !per_bad && !lines_bad -> LOCKED,
//             else stay VERIFY with err_f<=0 (retry next frame).
//     LOCKED: per_bad, lines_bad, or per_cnt==2047 -> SEARCH; same edge: locked<=0, timing_err<=1.
//   locked <= (next state==LOCKED); timing_err high exactly one cycle per loss of lock, never outside LOCKED.
//   The first FS after SEARCH never locks: lock needs one full verified frame (2 FS).
//   Counters x/y run regardless of lock; only active_pixel is gated by locked.
//   Reset mid-frame: all state cleared immediately; lock reacquired only via SEARCH->VERIFY->LOCKED.
// TESTING
//   1 Ideal 800x525 stream (hs low x=656..751, vs low lines 490..491) -> locked rises at 2nd FS;
//     x_count==656 at each hs_fall; y_count==490 at FS; line_period==800, frame_lines==525.
//   2 Locked, then one line 810 cycles -> at that hs_fall: locked 0, timing_err 1 cycle,
//     line_period==810; relock at 2nd FS after recovery.
//   3 Locked, hsync held high -> per_cnt saturates at 2047: locked 0, timing_err single pulse.
//   4 From reset, frame of 524 lines then good frames -> no lock at 524-line FS, timing_err stays 0;
//     locked at following FS.
//   5 vs_fall on same edge as hs_fall -> treated as FS: y_count==490, frame_lines updated.
//   6 Assert rst mid-line with no clock edge -> all outputs 0 immediately; release -> SEARCH, relock per test 1.

Source files
------------

// File: rtl/hvsync_detector.sv
// Sink-side 640x480@60 sync detector: recovers x/y position from incoming
// negative-polarity hsync/vsync and verifies line and frame timing before locking.
module hvsync_detector #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  x_count,
    output logic [9:0]  y_count,
    output logic        active_pixel,
    output logic        locked,
    output logic        timing_err,
    output logic [10:0] line_period,
    output logic [9:0]  frame_lines
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  X_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] PER_OK   = 11'(H_TOTAL);
    localparam logic [9:0]  LINES_OK = 10'(V_TOTAL);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

    state_e      state_q;
    logic        hs_q, vs_q, pend_q, pend_d;
    logic        err_q, locked_q, terr_q;
    logic [10:0] per_q, per_d, lp_q, lp_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  lc_q, lc_d, fl_q, fl_d;

    logic hs_fall, vs_fall, fs;
    logic per_bad, lines_bad, per_sat;

    assign hs_fall   = hs_q & ~hsync;
    assign vs_fall   = vs_q & ~vsync;
    assign fs        = hs_fall & (pend_q | vs_fall);
    assign per_bad   = hs_fall && (per_q != PER_OK);
    assign lines_bad = fs && (lc_q != LINES_OK);
    assign per_sat   = (per_q == 11'h7FF);

    always_comb begin
        per_d  = per_q;
        lp_d   = lp_q;
        pend_d = pend_q;
        x_d    = x_q;
        y_d    = y_q;
        lc_d   = lc_q;
        fl_d   = fl_q;
        if (hs_fall) begin
            per_d = 11'd1;
            lp_d  = per_q;
        end else if (!per_sat) begin
            per_d = per_q + 11'd1;
        end
        if (fs) begin
            pend_d = 1'b0;
        end else if (vs_fall) begin
            pend_d = 1'b1;
        end
        if (hs_fall) begin
            x_d = X_START;
        end else if (x_q == X_LAST) begin
            x_d = 10'd0;
        end else begin
            x_d = x_q + 10'd1;
        end
        // Row advances only on a free-running wrap, never on a resync edge
        if (fs) begin
            y_d = Y_START;
        end else if (!hs_fall && x_q == X_LAST) begin
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end
        if (fs) begin
            lc_d = 10'd1;
            fl_d = lc_q;
        end else if (hs_fall && lc_q != 10'h3FF) begin
            lc_d = lc_q + 10'd1;
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            pend_q <= 1'b0;
            per_q  <= '0;
            lp_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            lc_q   <= '0;
            fl_q   <= '0;
        end else begin
            hs_q   <= hsync;
            vs_q   <= vsync;
            pend_q <= pend_d;
            per_q  <= per_d;
            lp_q   <= lp_d;
            x_q    <= x_d;
            y_q    <= y_d;
            lc_q   <= lc_d;
            fl_q   <= fl_d;
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            unique case (state_q)
                SEARCH: begin
                    if (fs) begin
                        state_q <= VERIFY;
                        err_q   <= 1'b0;
                    end
                end
                VERIFY: begin
                    // Lock needs one whole clean frame between two frame starts
                    if (fs) begin
                        if (!err_q && !per_bad && !lines_bad) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                        err_q <= 1'b0;
                    end else if (per_bad) begin
                        err_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (per_bad || lines_bad || per_sat) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        terr_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign x_count      = x_q;
    assign y_count      = y_q;
    assign locked       = locked_q;
    assign timing_err   = terr_q;
    assign line_period  = lp_q;
    assign frame_lines  = fl_q;
    assign active_pixel = locked_q && (x_q < 10'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));

endmodule

// File: tb/tb_hvsync_detector.sv
// Randomized scoreboard bench for hvsync_detector using a reduced raster
// (32x20) so many frames, lock losses and relocks fit in a short run.
module tb_hvsync_detector;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XS = HA + HF;
    localparam int YS = VA + VF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [9:0]  x_count, y_count, frame_lines;
    logic [10:0] line_period;
    logic        active_pixel, locked, timing_err;

    hvsync_detector #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk_25(clk),
        .rst(rst),
        .hsync(hsync),
        .vsync(vsync),
        .x_count(x_count),
        .y_count(y_count),
        .active_pixel(active_pixel),
        .locked(locked),
        .timing_err(timing_err),
        .line_period(line_period),
        .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit fs;
        bit vsame;
    } line_t;

    typedef struct {
        int y;
        bit ychk;
        int lk;
        int lp;
        bit lpchk;
        int fl;
    } exp_t;

    line_t sched[$];
    exp_t  expq[$];
    int    n_chk = 0;
    int    n_fail = 0;

    int m_lk, m_seen, m_clean, m_since, m_fl, m_y, m_yk, m_prev, m_pk;
    int m_err = 0;
    int te_hi = 0;
    int te_rise = 0;
    logic te_prev = 1'b0;
    logic mon_prev = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int wraps(input int len);
        return (len - 1 >= HT - XS) ? 1 + (len - 1 - (HT - XS)) / HT : 0;
    endfunction

    task automatic model_reset();
        m_lk = 0; m_seen = 0; m_clean = 0; m_since = 0;
        m_fl = 0; m_y = 0; m_yk = 0; m_prev = 0; m_pk = 0;
    endtask

    // Line-level view: a frame locks when all its lines were HT long and
    // it held VT lines, provided a frame start was seen since lock was lost.
    task automatic model_fall(input line_t l);
        exp_t e;
        bit pok, lok;
        if (m_lk != 0 && m_pk != 0 && m_prev >= 2047) begin
            m_lk = 0; m_seen = 0; m_err++;
        end
        pok = (m_pk != 0) && (m_prev == HT);
        lok = (m_since == VT);
        if (m_lk != 0) begin
            if (!pok || (l.fs && !lok)) begin
                m_lk = 0; m_seen = 0; m_err++;
            end
        end else if (m_seen != 0) begin
            if (!pok) m_clean = 0;
            if (l.fs) begin
                if (m_clean != 0 && lok) m_lk = 1;
                m_clean = 1;
            end
        end else if (l.fs) begin
            m_seen = 1; m_clean = 1;
        end
        if (l.fs) begin
            m_fl = m_since; m_since = 1; m_y = YS; m_yk = 1;
        end else begin
            m_since = (m_since < 1023) ? m_since + 1 : 1023;
            if (m_yk != 0) m_y = (m_y + wraps(m_prev)) % VT;
        end
        e.y = m_y;
        e.ychk = (m_yk != 0);
        e.lk = m_lk;
        e.lp = (m_prev > 2047) ? 2047 : m_prev;
        e.lpchk = (m_pk != 0);
        e.fl = m_fl;
        expq.push_back(e);
        m_prev = l.len;
        m_pk = 1;
    endtask

    task automatic add_line(input int len, input bit fs, input bit vs);
        line_t l;
        l.len = len; l.fs = fs; l.vsame = vs;
        sched.push_back(l);
    endtask

    task automatic add_lines(input int n);
        for (int k = 0; k < n; k++) add_line(HT, 1'b0, 1'b0);
    endtask

    task automatic add_frame(input int n, input int bad_i, input int bad_len, input bit vs);
        for (int k = 0; k < n; k++)
            add_line((k == bad_i) ? bad_len : HT, k == 0, vs);
    endtask

    task automatic add_rand_frame();
        int n;
        n = VT;
        if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 1) ? VT + 1 : VT - 1;
        for (int k = 0; k < n; k++) begin
            int len;
            len = HT;
            if ($urandom_range(0, 14) == 0) len = HT - 2 + int'($urandom_range(0, 4));
            add_line(len, k == 0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic run_sched();
        for (int i = 0; i < sched.size(); i++) begin
            line_t l;
            bit early_next;
            l = sched[i];
            early_next = (i + 1 < sched.size()) && sched[i+1].fs && !sched[i+1].vsame;
            for (int c = 0; c < l.len; c++) begin
                @(negedge clk);
                if (c == 0) model_fall(l);
                hsync = (c < HS) ? 1'b0 : 1'b1;
                vsync = ((l.fs && c < 10) || (early_next && c >= l.len - 5)) ? 1'b0 : 1'b1;
            end
        end
        sched.delete();
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_x_count", x_count, 0);
        chk("rst_y_count", y_count, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timing_err", timing_err, 0);
        chk("rst_line_period", line_period, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_active_pixel", active_pixel, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (timing_err === 1'b1) te_hi++;
        if (timing_err === 1'b1 && te_prev !== 1'b1) te_rise++;
        te_prev = timing_err;
    end

    initial begin : monitor
        exp_t e;
        bit fall;
        forever begin
            @(posedge clk);
            fall = mon_prev && !hsync && !rst;
            mon_prev = hsync;
            if (fall) begin
                @(negedge clk);
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got empty queue, expected an entry");
                end else begin
                    e = expq.pop_front();
                    chk("x_at_hsfall", x_count, XS);
                    chk("locked_at_hsfall", locked, e.lk);
                    chk("frame_lines", frame_lines, e.fl);
                    chk("active_at_hsfall", active_pixel, 0);
                    if (e.lpchk) chk("line_period", line_period, e.lp);
                    if (e.ychk) begin
                        chk("y_at_hsfall", y_count, e.y);
                        repeat (HT - XS) @(negedge clk);
                        chk("x_wrap", x_count, 0);
                        chk("y_wrap", y_count, (e.y + 1) % VT);
                        chk("active_wrap", active_pixel,
                            int'(e.lk != 0 && ((e.y + 1) % VT) < VA));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        model_reset();
        do_reset();
        add_lines(1 + int'($urandom_range(0, 3)));
        add_frame(VT, -1, 0, 1'b0);
        add_frame(VT, -1, 0, 1'b1);
        add_frame(VT, -1, 0, 1'b0);
        add_frame(VT, -1, 0, 1'b1);
        add_frame(VT, 7, HT + 2, 1'b0);
        repeat (3) add_frame(VT, -1, 0, 1'b0);
        add_frame(VT, 5, 2100, 1'b1);
        repeat (3) add_frame(VT, -1, 0, 1'b1);
        repeat (8) add_rand_frame();
        repeat (2) add_frame(VT, -1, 0, 1'b0);
        add_lines(2);
        run_sched();
        do_reset();
        add_lines(2);
        add_frame(VT - 1, -1, 0, 1'b0);
        repeat (3) add_frame(VT, -1, 0, 1'b1);
        add_lines(2);
        run_sched();
        repeat (5) @(negedge clk);
        chk("sb_drained", expq.size(), 0);
        chk("locked_end", locked, m_lk);
        chk("terr_pulses", te_rise, m_err);
        chk("terr_cycles", te_hi, m_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
